// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

  // Read-mode selectors for the FWFT parameter
  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // Pointer/count width: one extra wrap bit over the memory address
  function automatic int cnt_w(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port: store on the accepted-write edge
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO: pointers, occupancy, status and sticky
// flags, and either a registered read or a first-word-fall-through output.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = MODE_STD,
  parameter int AF_LEVEL   = 28,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  Wr_enable,
  input  logic                  Read_enable,
  input  logic                  flush,
  input  logic                  clear_flags,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = cnt_w(ADDR_WIDTH);

  logic [CW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wr_acc, rd_acc;
  logic                  ovf_set, udf_set;

  // Occupancy falls out of the wrap-bit pointers; flags follow the same cycle
  assign count        = wr_ptr - rd_ptr;
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // flush swallows any same-cycle request, so those are neither accepted
  // nor treated as violations
  assign wr_acc  = Wr_enable   && !full  && !flush;
  assign rd_acc  = Read_enable && !empty && !flush;
  assign ovf_set = Wr_enable   &&  full  && !flush;
  assign udf_set = Read_enable &&  empty && !flush;

  // Pointer update: flush returns both to zero, otherwise advance on accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + CW'(1);
    end
  end

  // Sticky violation flags; a new violation beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow  & ~clear_flags);
      underflow <= udf_set | (underflow & ~clear_flags);
    end
  end

  fifo_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr[ADDR_WIDTH-1:0]),
    .wdata(data_in),
    .raddr(rd_ptr[ADDR_WIDTH-1:0]),
    .rdata(rdata)
  );

  if (FWFT == MODE_FWFT) begin : g_fwft
    // Head word is presented directly; zero while nothing is stored
    assign data_out = empty ? '0 : rdata;
    assign rd_valid = !empty;
  end else begin : g_std
    localparam int STAGES = 1;
    logic [STAGES:0]       vld_pipe;
    logic [STAGES-1:0]     vld_q;
    logic [DATA_WIDTH-1:0] dout_q;

    assign vld_pipe = {vld_q, rd_acc};

    // Read-valid tracks each accepted read one cycle later
    always_ff @(posedge clk or posedge reset) begin
      if (reset) vld_q <= '0;
      else       vld_q <= vld_pipe[STAGES-1:0];
    end

    // Output register loads the head word on an accepted read, else holds
    always_ff @(posedge clk or posedge reset) begin
      if (reset)       dout_q <= '0;
      else if (rd_acc) dout_q <= rdata;
    end

    assign data_out = dout_q;
    assign rd_valid = vld_pipe[STAGES];
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: standard-mode and FWFT instances share one stimulus stream.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       Wr_enable = 1'b0;
  logic       Read_enable = 1'b0;
  logic       flush = 1'b0;
  logic       clear_flags = 1'b0;

  logic [7:0] s_data_out, f_data_out;
  logic       s_rd_valid, f_rd_valid;
  logic       s_full, f_full, s_empty, f_empty;
  logic       s_af, f_af, s_ae, f_ae;
  logic [5:0] s_count, f_count;
  logic       s_ovf, f_ovf, s_udf, f_udf;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.FWFT(0)) u_std (
    .clk(clk), .reset(reset), .data_in(data_in), .Wr_enable(Wr_enable),
    .Read_enable(Read_enable), .flush(flush), .clear_flags(clear_flags),
    .data_out(s_data_out), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo_param #(.FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .data_in(data_in), .Wr_enable(Wr_enable),
    .Read_enable(Read_enable), .flush(flush), .clear_flags(clear_flags),
    .data_out(f_data_out), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    total_cnt++; if (s_count !== 6'd0) $display("FAIL rst_count got %0d want 0", s_count); else pass_cnt++;
    total_cnt++; if ({s_empty, s_full, s_ae, s_af} !== 4'b1010) $display("FAIL rst_flags got %b want 1010", {s_empty, s_full, s_ae, s_af}); else pass_cnt++;
    total_cnt++; if ({s_data_out, s_rd_valid, s_ovf, s_udf} !== 11'h0) $display("FAIL rst_out got %h want 000", {s_data_out, s_rd_valid, s_ovf, s_udf}); else pass_cnt++;
    total_cnt++; if ({f_data_out, f_rd_valid, f_empty} !== 10'h001) $display("FAIL rst_fwft got %h want 001", {f_data_out, f_rd_valid, f_empty}); else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_underflow();
    Read_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if ({s_rd_valid, s_data_out, s_count} !== 15'h0) $display("FAIL udf_idle[%0d] got v=%b d=%h c=%0d want 0/00/0", i, s_rd_valid, s_data_out, s_count); else pass_cnt++;
    end
    Read_enable = 1'b0;
    total_cnt++; if (s_udf !== 1'b1) $display("FAIL udf_set got %b want 1", s_udf); else pass_cnt++;
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    total_cnt++; if (s_udf !== 1'b0) $display("FAIL udf_clear got %b want 0", s_udf); else pass_cnt++;
  endtask

  task automatic test_basic();
    Wr_enable = 1'b1; data_in = 8'h00;
    tick();
    total_cnt++; if (s_count !== 6'd1) $display("FAIL basic_c1 got %0d want 1", s_count); else pass_cnt++;
    data_in = 8'h55;
    tick();
    total_cnt++; if (s_count !== 6'd2) $display("FAIL basic_c2 got %0d want 2", s_count); else pass_cnt++;
    Wr_enable = 1'b0; Read_enable = 1'b1;
    tick();
    total_cnt++; if ({s_rd_valid, s_data_out, s_count} !== {1'b1, 8'h00, 6'd1}) $display("FAIL basic_rd1 got v=%b d=%h c=%0d want 1/00/1", s_rd_valid, s_data_out, s_count); else pass_cnt++;
    tick();
    Read_enable = 1'b0;
    total_cnt++; if ({s_rd_valid, s_data_out, s_count, s_empty} !== {1'b1, 8'h55, 6'd0, 1'b1}) $display("FAIL basic_rd2 got v=%b d=%h c=%0d e=%b want 1/55/0/1", s_rd_valid, s_data_out, s_count, s_empty); else pass_cnt++;
    tick();
    total_cnt++; if ({s_rd_valid, s_data_out} !== {1'b0, 8'h55}) $display("FAIL basic_hold got v=%b d=%h want 0/55", s_rd_valid, s_data_out); else pass_cnt++;
  endtask

  task automatic test_fill();
    Wr_enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      data_in = 8'(i);
      tick();
      total_cnt++; if ({s_count, s_af, s_full} !== {6'(i + 1), (i + 1) >= 28, (i + 1) == 32}) $display("FAIL fill[%0d] got c=%0d af=%b f=%b want c=%0d", i, s_count, s_af, s_full, i + 1); else pass_cnt++;
    end
    data_in = 8'hAA;
    tick();
    Wr_enable = 1'b0;
    total_cnt++; if ({s_ovf, s_count} !== {1'b1, 6'd32}) $display("FAIL ovf_set got o=%b c=%0d want 1/32", s_ovf, s_count); else pass_cnt++;
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    total_cnt++; if (s_ovf !== 1'b0) $display("FAIL ovf_clear got %b want 0", s_ovf); else pass_cnt++;
    Read_enable = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick();
      total_cnt++; if ({s_rd_valid, s_data_out, s_count, s_ae} !== {1'b1, 8'(k), 6'(31 - k), (31 - k) <= 2}) $display("FAIL drain[%0d] got v=%b d=%h c=%0d ae=%b want d=%h c=%0d", k, s_rd_valid, s_data_out, s_count, s_ae, k, 31 - k); else pass_cnt++;
    end
    Read_enable = 1'b0;
    total_cnt++; if (s_empty !== 1'b1) $display("FAIL drain_empty got %b want 1", s_empty); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    Wr_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 8'(8'h80 + i);
      tick();
    end
    Read_enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      data_in = 8'(8'h85 + i);
      tick();
      total_cnt++; if ({s_count, s_rd_valid, s_data_out} !== {6'd5, 1'b1, 8'(8'h80 + i)}) $display("FAIL b2b[%0d] got c=%0d v=%b d=%h want 5/1/%h", i, s_count, s_rd_valid, s_data_out, 8'(8'h80 + i)); else pass_cnt++;
    end
    Wr_enable = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      total_cnt++; if ({s_data_out, s_count} !== {8'(8'hA8 + j), 6'(4 - j)}) $display("FAIL b2b_tail[%0d] got d=%h c=%0d want %h/%0d", j, s_data_out, s_count, 8'(8'hA8 + j), 4 - j); else pass_cnt++;
    end
    Read_enable = 1'b0;
    tick();
  endtask

  task automatic test_fwft();
    total_cnt++; if ({f_empty, f_data_out} !== 9'h100) $display("FAIL fwft_pre got e=%b d=%h want 1/00", f_empty, f_data_out); else pass_cnt++;
    Wr_enable = 1'b1; data_in = 8'h3C;
    tick();
    Wr_enable = 1'b0;
    total_cnt++; if ({f_rd_valid, f_data_out} !== {1'b1, 8'h3C}) $display("FAIL fwft_show got v=%b d=%h want 1/3c", f_rd_valid, f_data_out); else pass_cnt++;
    Read_enable = 1'b1;
    tick();
    Read_enable = 1'b0;
    total_cnt++; if ({f_empty, f_rd_valid, f_data_out} !== {1'b1, 1'b0, 8'h00}) $display("FAIL fwft_pop got e=%b v=%b d=%h want 1/0/00", f_empty, f_rd_valid, f_data_out); else pass_cnt++;
    total_cnt++; if ({s_rd_valid, s_data_out} !== {1'b1, 8'h3C}) $display("FAIL std_pop got v=%b d=%h want 1/3c", s_rd_valid, s_data_out); else pass_cnt++;
  endtask

  task automatic test_flush_reset();
    Wr_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 8'(8'h10 + i);
      tick();
    end
    total_cnt++; if (s_count !== 6'd10) $display("FAIL flush_pre got %0d want 10", s_count); else pass_cnt++;
    flush = 1'b1; data_in = 8'hEE;
    tick();
    flush = 1'b0; Wr_enable = 1'b0;
    total_cnt++; if ({s_count, s_empty, s_rd_valid, s_data_out} !== {6'd0, 1'b1, 1'b0, 8'h3C}) $display("FAIL flush got c=%0d e=%b v=%b d=%h want 0/1/0/3c", s_count, s_empty, s_rd_valid, s_data_out); else pass_cnt++;
    total_cnt++; if ({f_count, f_data_out, f_rd_valid} !== 15'h0) $display("FAIL flush_fwft got c=%0d d=%h v=%b want 0/00/0", f_count, f_data_out, f_rd_valid); else pass_cnt++;
    tick();
    total_cnt++; if ({s_count, s_ovf} !== 7'h0) $display("FAIL flush_drop got c=%0d o=%b want 0/0", s_count, s_ovf); else pass_cnt++;
    Read_enable = 1'b1;
    tick();
    Read_enable = 1'b0;
    total_cnt++; if (s_udf !== 1'b1) $display("FAIL udf_again got %b want 1", s_udf); else pass_cnt++;
    Wr_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 8'(8'h20 + i);
      tick();
    end
    Wr_enable = 1'b0;
    total_cnt++; if (s_count !== 6'd10) $display("FAIL refill got %0d want 10", s_count); else pass_cnt++;
    #3 reset = 1'b1;
    #1;
    total_cnt++; if ({s_count, s_empty, s_ae, s_af, s_full} !== {6'd0, 4'b1100}) $display("FAIL midrst_status got c=%0d e=%b ae=%b af=%b f=%b want 0/1/1/0/0", s_count, s_empty, s_ae, s_af, s_full); else pass_cnt++;
    total_cnt++; if ({s_data_out, s_rd_valid, s_ovf, s_udf} !== 11'h0) $display("FAIL midrst_out got d=%h v=%b o=%b u=%b want 00/0/0/0", s_data_out, s_rd_valid, s_ovf, s_udf); else pass_cnt++;
    total_cnt++; if ({f_count, f_data_out, f_rd_valid} !== 15'h0) $display("FAIL midrst_fwft got c=%0d d=%h v=%b want 0/00/0", f_count, f_data_out, f_rd_valid); else pass_cnt++;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_underflow();
    test_basic();
    test_fill();
    test_back_to_back();
    test_fwft();
    test_flush_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
